fp_add_sub_align: RTL and testbench
===================================

Name: fp_add_sub_align

Overview:
- Front-end stage of the single-precision IEEE-754 add/sub datapath. Sits directly upstream of the add/sub core.
- Accepts raw operands a, b and operation_select.
- Classifies special operands, orders the operands by magnitude, computes the effective operation and aligns the smaller significand, including guard/round/sticky bits.
- 2-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width
- GRS_W, 3, extra low-order alignment bits (guard, round, sticky)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand transfer request
- in_ready  out  1  stage can accept operands
- a  in  32  operand A, IEEE-754 single
- b  in  32  operand B, IEEE-754 single
- operation_select  in  1  1 = a+b, 0 = a-b
- out_valid  out  1  aligned operands available
- out_ready  in  1  downstream accepts
- out_sign  out  1  sign of larger-magnitude operand (after the effective sign of b is applied)
- out_exp  out  8  exponent of larger operand (0 promoted to 1 for subnormals)
- out_mant_big  out  27  {hidden, fraction, 3'b000}
- out_mant_small  out  27  smaller significand, right-shifted, bit 0 = sticky
- out_eff_sub  out  1  magnitudes are to be subtracted
- out_swap  out  1  b had the larger magnitude
- out_special  out  1  out_special_result is final; core bypasses arithmetic
- out_special_result  out  32  precomputed result for NaN/Inf cases

Behaviour:
- Reset (rst=1 at posedge): both stage valids cleared; all registered outputs zero. in_ready=1 in the first cycle after reset. Reset mid-operation discards in-flight data and produces no out_valid pulse.
- Handshake:
  - Transfer occurs when valid&&ready are high at posedge.
  - Each stage loads when empty or when its content advances in the same cycle.
  - in_ready = !s1_valid || (s1 advances). Combinational, with no path from in_valid.
  - While out_valid=1 && out_ready=0, all out_* hold stable.
- Latency: 2 cycles from input transfer to out_valid with out_ready=1. Throughput is 1 per cycle. Order is preserved; no drops or duplicates.
- Stage 1 (unpack/compare):
  - Effective sign of b: eb = b[31] ^ ~operation_select.
  - eff_sub = a[31] ^ eb.
  - Swap when b[30:0] > a[30:0], unsigned compare. Equal magnitudes do not swap.
  - Hidden bit = (exp != 0). Effective exponent = max(exp, 1).
  - diff = exp_big - exp_small, 8-bit, never negative after swap.
  - out_sign = swap ? eb : a[31].
- Special classification (registered in stage 1, carried through stage 2):
  - Any NaN input (exp=FF, frac!=0): special=1, result 32'h7FC00000.
  - Both inf with eff_sub=1: special=1, result 32'h7FC00000.
  - Otherwise any inf: special=1, result = that inf with its effective sign (a[31] for a, eb for b).
  - All other cases: special=0, result 0.
- Stage 2 (align):
  - mant_small = small_sig >> diff. The shifted-out bits are ORed into bit 0.
  - diff >= 27: mant_small = 27'h1 if small_sig != 0, else 0.
  - diff = 0: no shift.
- Zero operands are not special. They align normally, yielding a zero significand.

Test Plan:
- Basic add with swap: a=3F800000, b=40000000, op_sel=1, out_ready=1.
  - 2 cycles later out_valid=1, swap=1, exp=80, mant_big=27'h4000000, mant_small=27'h2000000, eff_sub=0, sign=0, special=0.
- Equal operands, subtract: a=b=3F800000, op_sel=0.
  - eff_sub=1, swap=0, mant_big=mant_small=27'h4000000, sign=0.
- Infinity cases:
  - a=7F800000, b=FF800000, op_sel=1: special=1, result=7FC00000.
  - Same operands with op_sel=0: special=1, result=7F800000.
  - a=7FC00001 (NaN), any b: special=1, result=7FC00000.
- Sticky alignment:
  - a=4B800000, b=3F800001, add: diff=24, mant_small=27'h5.
  - a=4F000000, b=3F800000: diff=31, mant_small=27'h1.
  - a=4F000000, b=00000000: mant_small=0.
- Backpressure: 5 back-to-back transactions, out_ready low for cycles 3-6.
  - in_ready drops once both stages are full.
  - Outputs stay stable while stalled.
  - All 5 results emerge in order, each exactly once.
- Reset mid-stream: assert rst for 1 cycle with both stages valid.
  - Next cycle out_valid=0, in_ready=1, outputs zero.
  - A following transaction completes with 2-cycle latency.

Source files
------------

// File: rtl/fp_add_sub_align.sv
// fp_add_sub_align: front-end alignment stage for single-precision add/sub.
// Stage 1 unpacks both operands, classifies NaN/Inf, orders them by magnitude
// and computes the effective operation. Stage 2 right-shifts the smaller
// significand by the exponent difference and folds shifted-out bits into a
// sticky bit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake for a, b, operation_select
//   out_valid/out_ready       downstream handshake for the aligned bundle
//   out_sign, out_exp         sign and effective exponent of the larger operand
//   out_mant_big/small        {hidden, fraction, GRS} significands, small one aligned
//   out_eff_sub, out_swap     effective subtract, b was the larger magnitude
//   out_special(_result)      NaN/Inf bypass flag and its final result
module fp_add_sub_align #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned GRS_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   input  logic                     operation_select,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sign,
   output logic [EXP_W-1:0]         out_exp,
   output logic [MAN_W+GRS_W:0]     out_mant_big,
   output logic [MAN_W+GRS_W:0]     out_mant_small,
   output logic                     out_eff_sub,
   output logic                     out_swap,
   output logic                     out_special,
   output logic [EXP_W+MAN_W:0]     out_special_result
);

   localparam int unsigned FP_W  = EXP_W + MAN_W + 1;
   localparam int unsigned MAG_W = FP_W - 1;
   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned ALN_W = SIG_W + GRS_W;

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [EXP_W-1:0] DIFF_SAT = EXP_W'(ALN_W);
   localparam logic [FP_W-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   // Stage 1 payload: ordered operands and classification
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig_big;
      logic [SIG_W-1:0] sig_small;
      logic [EXP_W-1:0] diff;
      logic             eff_sub;
      logic             swap;
      logic             special;
      logic [FP_W-1:0]  special_result;
   } s1_t;

   // Stage 2 payload: the aligned bundle presented downstream
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [ALN_W-1:0] mant_big;
      logic [ALN_W-1:0] mant_small;
      logic             eff_sub;
      logic             swap;
      logic             special;
      logic [FP_W-1:0]  special_result;
   } s2_t;

   logic             s1_valid_q;
   s1_t              s1_q, s1_d;
   logic             out_valid_q;
   s2_t              s2_q, s2_d;

   logic             s2_en;
   logic             s1_adv;
   logic             s1_en;

   logic             eb;
   logic             eff_sub;
   logic             swap;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [EXP_W-1:0] a_eexp, b_eexp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic [SIG_W-1:0] a_sig, b_sig;
   logic             a_nan, b_nan, a_inf, b_inf;

   logic [ALN_W-1:0] small_ext;
   logic [ALN_W-1:0] shifted;
   logic [ALN_W-1:0] lost_mask;
   logic             lost;
   logic [ALN_W-1:0] mant_small;

   // Handshake: stage 2 loads when empty or draining; stage 1 follows it
   always_comb begin
      s2_en    = !out_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_en;
      in_ready = !s1_valid_q || s1_adv;
      s1_en    = in_valid && in_ready;
   end

   // Stage 1: unpack, classify, order by magnitude
   always_comb begin
      s1_d    = '0;
      eb      = b[FP_W-1] ^ ~operation_select;
      eff_sub = a[FP_W-1] ^ eb;
      // equal magnitudes keep a as the larger operand
      swap    = b[MAG_W-1:0] > a[MAG_W-1:0];

      a_exp  = a[MAG_W-1 -: EXP_W];
      b_exp  = b[MAG_W-1 -: EXP_W];
      a_frac = a[MAN_W-1:0];
      b_frac = b[MAN_W-1:0];
      // subnormals share exponent 1 with the smallest normals
      a_eexp = (a_exp == '0) ? EXP_ONE : a_exp;
      b_eexp = (b_exp == '0) ? EXP_ONE : b_exp;
      a_sig  = {a_exp != '0, a_frac};
      b_sig  = {b_exp != '0, b_frac};

      a_nan = (a_exp == EXP_ONES) && (a_frac != '0);
      b_nan = (b_exp == EXP_ONES) && (b_frac != '0);
      a_inf = (a_exp == EXP_ONES) && (a_frac == '0);
      b_inf = (b_exp == EXP_ONES) && (b_frac == '0);

      s1_d.eff_sub = eff_sub;
      s1_d.swap    = swap;
      if (swap) begin
         s1_d.sign      = eb;
         s1_d.exp       = b_eexp;
         s1_d.sig_big   = b_sig;
         s1_d.sig_small = a_sig;
         s1_d.diff      = b_eexp - a_eexp;
      end else begin
         s1_d.sign      = a[FP_W-1];
         s1_d.exp       = a_eexp;
         s1_d.sig_big   = a_sig;
         s1_d.sig_small = b_sig;
         s1_d.diff      = a_eexp - b_eexp;
      end

      // NaN wins, then inf-inf of opposite effective signs, then a lone inf
      if (a_nan || b_nan) begin
         s1_d.special        = 1'b1;
         s1_d.special_result = QNAN;
      end else if (a_inf && b_inf && eff_sub) begin
         s1_d.special        = 1'b1;
         s1_d.special_result = QNAN;
      end else if (a_inf) begin
         s1_d.special        = 1'b1;
         s1_d.special_result = {a[FP_W-1], EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         s1_d.special        = 1'b1;
         s1_d.special_result = {eb, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   // Stage 2: align smaller significand, collapsing shifted-out bits to sticky
   always_comb begin
      small_ext  = {s1_q.sig_small, {GRS_W{1'b0}}};
      shifted    = '0;
      lost_mask  = '0;
      lost       = 1'b0;
      mant_small = '0;
      if (s1_q.diff >= DIFF_SAT) begin
         mant_small = ALN_W'(|s1_q.sig_small);
      end else begin
         shifted    = small_ext >> s1_q.diff;
         lost_mask  = ~({ALN_W{1'b1}} << s1_q.diff);
         lost       = |(small_ext & lost_mask);
         mant_small = shifted | ALN_W'(lost);
      end

      s2_d                = '0;
      s2_d.sign           = s1_q.sign;
      s2_d.exp            = s1_q.exp;
      s2_d.mant_big       = {s1_q.sig_big, {GRS_W{1'b0}}};
      s2_d.mant_small     = mant_small;
      s2_d.eff_sub        = s1_q.eff_sub;
      s2_d.swap           = s1_q.swap;
      s2_d.special        = s1_q.special;
      s2_d.special_result = s1_q.special_result;
   end

   // Pipeline registers; payloads only load on an accepted transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         s2_q        <= '0;
      end else begin
         if (in_ready) s1_valid_q  <= in_valid;
         if (s1_en)    s1_q        <= s1_d;
         if (s2_en)    out_valid_q <= s1_valid_q;
         if (s1_adv)   s2_q        <= s2_d;
      end
   end

   always_comb begin
      out_valid          = out_valid_q;
      out_sign           = s2_q.sign;
      out_exp            = s2_q.exp;
      out_mant_big       = s2_q.mant_big;
      out_mant_small     = s2_q.mant_small;
      out_eff_sub        = s2_q.eff_sub;
      out_swap           = s2_q.swap;
      out_special        = s2_q.special;
      out_special_result = s2_q.special_result;
   end

endmodule

// File: tb/tb_fp_add_sub_align.sv
// tb_fp_add_sub_align: scoreboard bench for the add/sub alignment stage.
module tb_fp_add_sub_align;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        op_sel;
   logic        out_valid;
   logic        out_ready;
   logic        out_sign;
   logic [7:0]  out_exp;
   logic [26:0] out_mant_big, out_mant_small;
   logic        out_eff_sub, out_swap, out_special;
   logic [31:0] out_special_result;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [26:0] mb;
      logic [26:0] ms;
      logic        eff_sub;
      logic        swap;
      logic        special;
      logic [31:0] res;
      int          due;
      logic        chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   ir_low_seen = 0;
   logic stall_prev = 1'b0;
   logic [97:0] saved;
   logic [97:0] bundle;

   fp_add_sub_align dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .operation_select(op_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp),
      .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
      .out_eff_sub(out_eff_sub), .out_swap(out_swap),
      .out_special(out_special), .out_special_result(out_special_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bundle = {out_sign, out_exp, out_mant_big, out_mant_small,
                    out_eff_sub, out_swap, out_special, out_special_result};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [26:0] mb,
                               input logic [26:0] ms, input logic es, input logic sw,
                               input logic sp, input logic [31:0] r);
      exp_t t;
      t.sign = s; t.exp = e; t.mb = mb; t.ms = ms; t.eff_sub = es; t.swap = sw;
      t.special = sp; t.res = r; t.due = 0; t.chk_lat = 1'b1;
      return t;
   endfunction

   // Reference: bit-serial alignment with a running sticky
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
      exp_t t;
      logic ey, sw, stick, xnan, ynan, xinf, yinf;
      logic [30:0] bigm, smallm;
      int eb_i, es_i;
      logic [26:0] m;
      ey = y[31] ^ ~op;
      sw = (y[30:0] > x[30:0]);
      bigm   = sw ? y[30:0] : x[30:0];
      smallm = sw ? x[30:0] : y[30:0];
      eb_i = (bigm[30:23] == 8'd0) ? 1 : int'(bigm[30:23]);
      es_i = (smallm[30:23] == 8'd0) ? 1 : int'(smallm[30:23]);
      m = {smallm[30:23] != 8'd0, smallm[22:0], 3'b000};
      stick = 1'b0;
      for (int i = 0; i < eb_i - es_i; i++) begin
         stick = stick | m[0];
         m = m >> 1;
      end
      m[0] = m[0] | stick;
      t.sign = sw ? ey : x[31];
      t.exp = 8'(eb_i);
      t.mb = {bigm[30:23] != 8'd0, bigm[22:0], 3'b000};
      t.ms = m;
      t.eff_sub = x[31] ^ ey;
      t.swap = sw;
      xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xinf = (x[30:0] == 31'h7F800000);
      yinf = (y[30:0] == 31'h7F800000);
      t.special = xnan | ynan | xinf | yinf;
      if (xnan || ynan || (xinf && yinf && t.eff_sub)) t.res = 32'h7FC00000;
      else if (xinf) t.res = {x[31], 31'h7F800000};
      else if (yinf) t.res = {ey, 31'h7F800000};
      else t.res = 32'h0;
      t.due = 0;
      t.chk_lat = 1'b0;
      return t;
   endfunction

   // Drive one operand pair; entered and left at posedge+1
   task automatic drive(input logic [31:0] xa, input logic [31:0] xb, input logic xop, input exp_t e);
      logic done;
      done = 1'b0;
      a = xa; b = xb; op_sel = xop; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.due = cyc + 2;
            sb.push_back(e);
            done = 1'b1;
            break;
         end
      end
      if (!done) check("in_timeout", 64'(done), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: scoreboard compare and stall stability
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check("stall_hold", 64'(bundle == saved), 64'd1);
         stall_prev = out_valid && !out_ready;
         saved = bundle;
         if (in_valid && !in_ready) ir_low_seen++;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check("sign",     64'(out_sign), 64'(e.sign));
               check("exp",      64'(out_exp), 64'(e.exp));
               check("mant_big", 64'(out_mant_big), 64'(e.mb));
               check("mant_sml", 64'(out_mant_small), 64'(e.ms));
               check("eff_sub",  64'(out_eff_sub), 64'(e.eff_sub));
               check("swap",     64'(out_swap), 64'(e.swap));
               check("special",  64'(out_special), 64'(e.special));
               check("spec_res", 64'(out_special_result), 64'(e.res));
               if (e.chk_lat) check("latency", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rop;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sel = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready), 64'd1);
      check("rst_bundle",    64'(|bundle), 64'd0);
      @(posedge clk); #1;

      // Directed cases, back to back with downstream always ready
      drive(32'h3F800000, 32'h40000000, 1'b1, mk(0, 8'h80, 27'h4000000, 27'h2000000, 0, 1, 0, 32'h0));
      drive(32'h3F800000, 32'h3F800000, 1'b0, mk(0, 8'h7F, 27'h4000000, 27'h4000000, 1, 0, 0, 32'h0));
      drive(32'h7F800000, 32'hFF800000, 1'b1, mk(0, 8'hFF, 27'h4000000, 27'h4000000, 1, 0, 1, 32'h7FC00000));
      drive(32'h7F800000, 32'hFF800000, 1'b0, mk(0, 8'hFF, 27'h4000000, 27'h4000000, 0, 0, 1, 32'h7F800000));
      drive(32'h7FC00001, 32'h3F800000, 1'b1, mk(0, 8'hFF, 27'h6000008, 27'h1, 0, 0, 1, 32'h7FC00000));
      drive(32'h4B800000, 32'h3F800001, 1'b1, mk(0, 8'h97, 27'h4000000, 27'h5, 0, 0, 0, 32'h0));
      drive(32'h4F000000, 32'h3F800000, 1'b1, mk(0, 8'h9E, 27'h4000000, 27'h1, 0, 0, 0, 32'h0));
      drive(32'h4F000000, 32'h00000000, 1'b1, mk(0, 8'h9E, 27'h4000000, 27'h0, 0, 0, 0, 32'h0));
      drive(32'h00000003, 32'h00800001, 1'b0, mk(1, 8'h01, 27'h4000008, 27'h18, 1, 1, 0, 32'h0));
      drive(32'h3F800000, 32'h7F800000, 1'b0, mk(1, 8'hFF, 27'h4000000, 27'h1, 1, 1, 1, 32'hFF800000));
      drive(32'h41800000, 32'h3F800001, 1'b1, mk(0, 8'h83, 27'h4000000, 27'h400001, 0, 0, 0, 32'h0));
      drive(32'h4C000000, 32'h3F800001, 1'b1, mk(0, 8'h98, 27'h4000000, 27'h3, 0, 0, 0, 32'h0));
      drive(32'h4D000000, 32'h3F800000, 1'b1, mk(0, 8'h9A, 27'h4000000, 27'h1, 0, 0, 0, 32'h0));
      drive(32'hC0000000, 32'h3F800000, 1'b1, mk(1, 8'h80, 27'h4000000, 27'h2000000, 1, 0, 0, 32'h0));
      drain();
      @(posedge clk); #1;

      // Backpressure: 5 back-to-back transfers, out_ready low for cycles 3-6
      ir_low_seen = 0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               ra = $urandom;
               rb = $urandom;
               rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 31));
               rop = 1'($urandom_range(0, 1));
               drive(ra, rb, rop, model(ra, rb, rop));
            end
         end
         begin
            for (int i = 0; i < 12; i++) begin
               out_ready = !(i >= 3 && i <= 6);
               @(posedge clk); #1;
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check("in_ready_drop", 64'(ir_low_seen > 0), 64'd1);
      @(posedge clk); #1;

      // Reset with both stages occupied
      out_ready = 1'b0;
      drive(32'h3F800000, 32'h40000000, 1'b1, mk(0, 8'h80, 27'h4000000, 27'h2000000, 0, 1, 0, 32'h0));
      drive(32'h4B800000, 32'h3F800001, 1'b1, mk(0, 8'h97, 27'h4000000, 27'h5, 0, 0, 0, 32'h0));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      out_ready = 1'b1;
      @(negedge clk);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_in_ready",  64'(in_ready), 64'd1);
      check("mrst_bundle",    64'(|bundle), 64'd0);
      @(posedge clk); #1;
      drive(32'h4F000000, 32'h3F800000, 1'b1, mk(0, 8'h9E, 27'h4000000, 27'h1, 0, 0, 0, 32'h0));
      drain();
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
